piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_shift_tx_if.sv | 28 ++
 rtl/piso_bit_cnt.sv | 43 ++++
 rtl/piso_shift_tx.sv | 134 +++++++++++++
 tb/tb_piso_shift_tx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Purpose: shared types and constants for the piso_shift_tx serializer.
// Contents: FSM state encoding (IDLE, SHIFT, PARITY) and the default word width.
// Latency/backpressure: n/a (declarations only).
package piso_pkg;

  localparam int PISO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/piso_shift_tx_if.sv
// Purpose: load/serial bus of the piso_shift_tx serializer.
// Ports: PI/LOAD/LEFT_RIGHT from the word source, READY back to it;
//        SO/SO_VALID/DONE carry the serial stream out.
interface piso_shift_tx_if #(
  parameter int WIDTH = piso_pkg::PISO_WIDTH
);

  logic [WIDTH-1:0] PI;
  logic             LOAD;
  logic             LEFT_RIGHT;
  logic             READY;
  logic             SO;
  logic             SO_VALID;
  logic             DONE;

  // Word source / testbench side.
  modport master (
    output PI, LOAD, LEFT_RIGHT,
    input  READY, SO, SO_VALID, DONE
  );

  // Serializer side.
  modport slave (
    input  PI, LOAD, LEFT_RIGHT,
    output READY, SO, SO_VALID, DONE
  );

endinterface

// File: rtl/piso_bit_cnt.sv
// Purpose: index of the frame data bit currently on SO; saturates at WIDTH-1.
// Ports: clk, rst (sync, active high), clr (start of frame), en (advance),
//        cnt (current index), tc (index is WIDTH-1, i.e. last data bit).
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(WIDTH)-1:0]   cnt,
  output logic                       tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CW'(WIDTH - 1));

  // Clear wins over enable so a back-to-back reload restarts at bit 0;
  // stopping at tc keeps the count from wrapping inside a frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Purpose: parallel-in serial-out transmitter, MSB- or LSB-first per word;
//          optional even-parity bit when PISO_SHIFT_TX_PARITY_EN is defined.
// Ports: C (clock), R (sync active-high reset), bus (piso_shift_tx_if.slave).
//        First bit on SO one cycle after load; READY high in IDLE and final bit cycle.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic                 C,
  input  logic                 R,
  piso_shift_tx_if.slave       bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic             so_q, so_d;
  logic             so_vld_q, so_vld_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
`ifdef PISO_SHIFT_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             cnt_en;

  assign accept = bus.LOAD & ready_q;
  assign cnt_en = (state_q == SHIFT) & ~tc;

  piso_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk (C),
    .rst (R),
    .clr (accept),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  // All outputs are registered: the _d values describe the cycle after the
  // coming edge. sreg_q keeps the bit currently on SO at its outgoing end,
  // so the next bit is always one position inward.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    dir_d    = dir_q;
    so_d     = 1'b0;
    so_vld_d = 1'b0;
    done_d   = 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
    par_d    = par_q;
`endif

    if (accept) begin
      state_d  = SHIFT;
      sreg_d   = bus.PI;
      dir_d    = bus.LEFT_RIGHT;
      so_d     = bus.LEFT_RIGHT ? bus.PI[0] : bus.PI[WIDTH-1];
      so_vld_d = 1'b1;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_d    = ^bus.PI;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (!tc) begin
            sreg_d   = dir_q ? (sreg_q >> 1) : (sreg_q << 1);
            so_d     = dir_q ? sreg_q[1] : sreg_q[WIDTH-2];
            so_vld_d = 1'b1;
`ifndef PISO_SHIFT_TX_PARITY_EN
            // Next bit shown is the last data bit, which ends the frame.
            done_d   = (cnt == CW'(WIDTH - 2));
`endif
          end else begin
`ifdef PISO_SHIFT_TX_PARITY_EN
            state_d  = PARITY;
            so_d     = par_q;
            so_vld_d = 1'b1;
            done_d   = 1'b1;
`else
            state_d  = IDLE;
`endif
          end
        end
`ifdef PISO_SHIFT_TX_PARITY_EN
        PARITY: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end

    // Ready next cycle if idle or showing the frame's final bit.
    ready_d = (state_d == IDLE) | done_d;
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      dir_q    <= 1'b0;
      so_q     <= 1'b0;
      so_vld_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      dir_q    <= dir_d;
      so_q     <= so_d;
      so_vld_q <= so_vld_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.READY    = ready_q;
  assign bus.SO       = so_q;
  assign bus.SO_VALID = so_vld_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Purpose: directed self-checking bench for piso_shift_tx (WIDTH = 8).
// Observed tuple per cycle is {SO, SO_VALID, DONE, READY}, sampled 1 time unit
// after the rising edge; expected values are hand-computed constants.
module tb_piso_shift_tx;

  logic C = 1'b0;
  logic R;

  piso_shift_tx_if #(.WIDTH(8)) bus ();

  piso_shift_tx #(.WIDTH(8)) dut (
    .C   (C),
    .R   (R),
    .bus (bus.slave)
  );

  always #5 C = ~C;

  int vecs = 0;
  int errs = 0;

  task automatic step();
    @(posedge C);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {bus.SO, bus.SO_VALID, bus.DONE, bus.READY};
  endfunction

  task automatic test_reset();
    R = 1'b1;
    bus.LOAD = 1'b0;
    bus.PI = 8'h00;
    bus.LEFT_RIGHT = 1'b0;
    step();
    step();
    vecs++;
    if (obs() !== 4'b0000) begin
      errs++;
      $display("FAIL reset_outputs: got %b required %b", obs(), 4'b0000);
    end
    R = 1'b0;
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL reset_release_ready: got %b required %b", obs(), 4'b0001);
    end
  endtask

  // seq[7-i] is frame bit i. PI and LEFT_RIGHT are disturbed every cycle.
  task automatic test_single_frame(input string name, input logic [7:0] word,
                                   input logic lr, input logic [7:0] seq);
    logic [3:0] e;
    bus.PI = word;
    bus.LEFT_RIGHT = lr;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      e = {seq[7-i], 1'b1, (i == 7), (i == 7)};
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL %s bit%0d: got %b required %b", name, i, obs(), e);
      end
      bus.PI = ~word;
      bus.LEFT_RIGHT = ~lr;
    end
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL %s idle_after: got %b required %b", name, obs(), 4'b0001);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    bus.PI = 8'hFF;
    bus.LEFT_RIGHT = 1'b0;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      e = {(j < 8), 1'b1, (j == 7 || j == 15), (j == 7 || j == 15)};
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL back_to_back cyc%0d: got %b required %b", j, obs(), e);
      end
      if (j == 7) begin
        bus.PI = 8'h00;
        bus.LOAD = 1'b1;
      end else begin
        bus.LOAD = 1'b0;
      end
    end
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL back_to_back idle_after: got %b required %b", obs(), 4'b0001);
    end
  endtask

  // LOAD held high: only C3 goes out, then 5A captured in its final-bit cycle.
  task automatic test_load_held();
    logic [15:0] seq;
    logic [3:0]  e;
    seq = 16'hC35A;
    bus.PI = 8'hC3;
    bus.LEFT_RIGHT = 1'b0;
    bus.LOAD = 1'b1;
    step();
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      e = {seq[15-j], 1'b1, (j == 7 || j == 15), (j == 7 || j == 15)};
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL load_held cyc%0d: got %b required %b", j, obs(), e);
      end
      if (j == 7) bus.PI = 8'h5A;
      else        bus.PI = j[0] ? 8'hFF : 8'h00;
      if (j >= 8) bus.LOAD = 1'b0;
    end
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL load_held idle_after: got %b required %b", obs(), 4'b0001);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq;
    logic [3:0] e;
    seq = 8'h3C;
    bus.PI = 8'h3C;
    bus.LEFT_RIGHT = 1'b0;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) step();
      e = {seq[7-i], 1'b1, 1'b0, 1'b0};
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL reset_mid bit%0d: got %b required %b", i, obs(), e);
      end
    end
    R = 1'b1;
    bus.LOAD = 1'b1;
    bus.PI = 8'hFF;
    step();
    vecs++;
    if (obs() !== 4'b0000) begin
      errs++;
      $display("FAIL reset_mid abort: got %b required %b", obs(), 4'b0000);
    end
    R = 1'b0;
    bus.LOAD = 1'b0;
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL reset_mid ready_after: got %b required %b", obs(), 4'b0001);
    end
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL reset_mid no_late_done: got %b required %b", obs(), 4'b0001);
    end
    // Reset and load in the same edge while READY is high: reset must win.
    bus.LOAD = 1'b1;
    bus.PI = 8'hFF;
    R = 1'b1;
    step();
    vecs++;
    if (obs() !== 4'b0000) begin
      errs++;
      $display("FAIL reset_over_load: got %b required %b", obs(), 4'b0000);
    end
    R = 1'b0;
    bus.LOAD = 1'b0;
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL reset_over_load idle: got %b required %b", obs(), 4'b0001);
    end
  endtask

`ifdef PISO_SHIFT_TX_PARITY_EN
  // 8'h07 MSB first plus even parity (three ones -> 1): seq[8-i] is bit i.
  task automatic test_parity();
    logic [8:0] seq;
    logic [3:0] e;
    seq = 9'b0_0000_1111;
    bus.PI = 8'h07;
    bus.LEFT_RIGHT = 1'b0;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      e = {seq[8-i], 1'b1, (i == 8), (i == 8)};
      vecs++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL parity bit%0d: got %b required %b", i, obs(), e);
      end
    end
    step();
    vecs++;
    if (obs() !== 4'b0001) begin
      errs++;
      $display("FAIL parity idle_after: got %b required %b", obs(), 4'b0001);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef PISO_SHIFT_TX_PARITY_EN
    test_parity();
`else
    test_single_frame("msb_a5", 8'hA5, 1'b0, 8'hA5);
    test_single_frame("lsb_a5", 8'hA5, 1'b1, 8'hA5);
    test_single_frame("lsb_01", 8'h01, 1'b1, 8'h80);
    test_single_frame("msb_01", 8'h01, 1'b0, 8'h01);
    test_back_to_back();
    test_load_held();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
